// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction-fetch stage: owns the PC, fetches one word per retirement.
// RESET_PC must be 4-byte aligned; the first fetch is not alignment-checked.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        next_pc_sel,
    input  logic [31:0] jb_pc,
    input  logic        core_ready,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic        misalign_err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_instret;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    // Bit 0 of the jump target is dropped as JALR requires; bit 1 set means misaligned.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = next_pc_sel ? w_pc_plus4 : (jb_pc & ~32'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= 32'h0000_0013;
            r_instret <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        r_inst  <= imem_resp_data;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (core_ready) begin
                        r_instret <= r_instret + 32'd1;
                        if (w_target[1]) begin
                            r_state <= S_ERR;
                        end else begin
                            r_pc    <= w_target;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ERR is only left through reset, so decoding it gives the sticky error flag.
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign misalign_err   = (r_state == S_ERR);
    assign inst           = r_inst;
    assign pc             = r_pc;
    assign instret        = r_instret;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        next_pc_sel;
    logic [31:0] jb_pc;
    logic        core_ready;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        misalign_err;
    logic [31:0] instret;

    int total;
    int bad;
    int resp_lat;
    logic spurious;

    logic [31:0] exp_req[$];
    logic [31:0] exp_ret[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .next_pc_sel     (next_pc_sel),
        .jb_pc           (jb_pc),
        .core_ready      (core_ready),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .pc              (pc),
        .inst_valid      (inst_valid),
        .misalign_err    (misalign_err),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hold(input string name);
        int k;
        k = 0;
        while (!inst_valid && k < 20) begin
            tick();
            k++;
        end
        chk({name, "_hold_reached"}, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_req_valid"},  {31'd0, imem_req_valid}, 32'd0);
        chk({name, "_inst_valid"}, {31'd0, inst_valid},     32'd0);
        chk({name, "_misalign"},   {31'd0, misalign_err},   32'd0);
        chk({name, "_pc"},         pc,                      32'h0000_0000);
        chk({name, "_inst"},       inst,                    32'h0000_0013);
        chk({name, "_instret"},    instret,                 32'd0);
    endtask

    // Memory: accepts a request, answers resp_lat cycles later; may drive junk when idle.
    initial begin
        int          pend;
        logic        acc;
        logic        rs;
        logic [31:0] a;
        pend = -1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        forever begin
            @(negedge clk);
            acc = imem_req_valid && imem_req_ready && rst_n;
            rs  = rst_n;
            a   = imem_req_addr;
            @(posedge clk);
            #1;
            if (!rs) pend = -1;
            if (acc) pend = resp_lat;
            if (pend == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = inst_of(a);
                pend = -1;
            end else begin
                imem_resp_valid = spurious;
                imem_resp_data  = 32'hDEAD_BEEF;
                if (pend > 0) pend--;
            end
        end
    end

    // Scoreboard monitor: requests and retirements are compared against queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                if (exp_req.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexpected actual=%h expected=none", imem_req_addr);
                end else begin
                    chk("req_addr", imem_req_addr, exp_req.pop_front());
                end
            end
            if (inst_valid && core_ready) begin
                if (exp_ret.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL retire_unexpected actual=%h expected=none", pc);
                end else begin
                    logic [31:0] ep;
                    ep = exp_ret.pop_front();
                    chk("retire_pc", pc, ep);
                    chk("retire_inst", inst, inst_of(ep));
                end
            end
        end
    end

    initial begin
        clk = 1'b0;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        next_pc_sel = 1'b1;
        jb_pc = 32'd0;
        core_ready = 1'b0;
        imem_req_ready = 1'b1;
        resp_lat = 0;
        spurious = 1'b0;

        repeat (3) tick();
        check_reset("rst0");

        // Sequential fetch 0,4,8 then branch to 0x40
        core_ready = 1'b1;
        exp_req.push_back(32'h0);  exp_ret.push_back(32'h0);
        exp_req.push_back(32'h4);  exp_ret.push_back(32'h4);
        exp_req.push_back(32'h8);  exp_ret.push_back(32'h8);
        exp_req.push_back(32'h40);
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("iv_cycle%0d", i), {31'd0, inst_valid}, (i % 3 == 0) ? 32'd1 : 32'd0);
        end
        chk("pc_before_branch", pc, 32'h8);
        next_pc_sel = 1'b0;
        jb_pc = 32'h40;
        tick();
        chk("instret_3", instret, 32'd3);
        chk("branch_addr", imem_req_addr, 32'h40);
        chk("branch_req_valid", {31'd0, imem_req_valid}, 32'd1);

        // JALR odd target 0x101 -> 0x100
        exp_ret.push_back(32'h40);
        exp_req.push_back(32'h100);
        wait_hold("h40");
        jb_pc = 32'h101;
        tick();
        chk("jalr_addr", imem_req_addr, 32'h100);
        chk("jalr_no_err", {31'd0, misalign_err}, 32'd0);

        exp_ret.push_back(32'h100);
        exp_req.push_back(32'h104);
        wait_hold("h100");
        next_pc_sel = 1'b1;
        tick();

        // Core stall in HOLD
        wait_hold("h104");
        core_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", pc, 32'h104);
            chk("stall_inst", inst, inst_of(32'h104));
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_instret", instret, 32'd5);
        end

        // Request backpressure with spurious responses
        imem_req_ready = 1'b0;
        spurious = 1'b1;
        core_ready = 1'b1;
        exp_ret.push_back(32'h104);
        exp_req.push_back(32'h108);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("bp_addr", imem_req_addr, 32'h108);
            chk("bp_inst_kept", inst, inst_of(32'h104));
            tick();
        end
        imem_req_ready = 1'b1;
        spurious = 1'b0;
        resp_lat = 3;
        wait_hold("h108");
        chk("delayed_inst", inst, inst_of(32'h108));

        // Reset while waiting for a response
        exp_ret.push_back(32'h108);
        exp_req.push_back(32'h10C);
        tick();
        tick();
        chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
        rst_n = 1'b0;
        tick();
        check_reset("rst_mid");
        resp_lat = 0;
        tick();

        // Counter wrap on a misaligned-target retire
        exp_req.push_back(32'h0);
        exp_ret.push_back(32'h0);
        rst_n = 1'b1;
        wait_hold("h0b");
        core_ready = 1'b0;
        force dut.r_instret = 32'hFFFF_FFFF;
        tick();
        release dut.r_instret;
        tick();
        chk("instret_preload", instret, 32'hFFFF_FFFF);
        next_pc_sel = 1'b0;
        jb_pc = 32'h102;
        core_ready = 1'b1;
        tick();
        chk("err_flag", {31'd0, misalign_err}, 32'd1);
        chk("err_instret_wrap", instret, 32'd0);
        chk("err_pc_kept", pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("err_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("err_sticky", {31'd0, misalign_err}, 32'd1);
            chk("err_no_inst", {31'd0, inst_valid}, 32'd0);
        end

        chk("req_queue_empty", exp_req.size(), 32'd0);
        chk("ret_queue_empty", exp_ret.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I single-cycle core; sits directly upstream of the decoder/controller.
- Owns the architectural PC and fetches one instruction per retirement from instruction memory over a valid/ready request and valid response interface.
- Holds the fetched word stable for the core until the core retires it.
- Consumes the controller's next_pc_sel and the jump/branch target to form the next PC.
- Counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be 4-byte aligned.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- next_pc_sel  in  1  from controller; 1 = PC+4, 0 = take jb_pc
- jb_pc  in  32  jump/branch target from the JB adder
- core_ready  in  1  core has executed the current instruction this cycle
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch byte address
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  read data valid
- imem_resp_data  in  32  instruction word
- inst  out  32  instruction to decoder
- pc  out  32  PC of inst
- inst_valid  out  1  inst/pc valid for execution
- misalign_err  out  1  sticky: fetch target not 4-byte aligned
- instret  out  32  retired-instruction counter

Behaviour:
- Reset: on any clock edge with rst_n=0:
  - state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (NOP).
  - inst_valid=0, imem_req_valid=0, misalign_err=0, instret=0.
  - Reset overrides all other activity in every state.
- Reset is shared with imem: imem drops in-flight responses on reset, so no stale response returns after reset.
- States: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: lasts exactly one cycle after reset release, then goes to REQ.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Stays in REQ while imem_req_ready=0; addr held stable.
  - On valid&ready, goes to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid=1: inst<=imem_resp_data, then go to HOLD.
  - A response is never accepted in the same cycle as its request; minimum request-to-HOLD latency is 2 cycles.
- HOLD:
  - inst_valid=1; inst and pc held stable while core_ready=0.
  - On core_ready=1 (retire):
    - instret<=instret+1, wrapping 32'hFFFF_FFFF to 0.
    - Next PC target t = next_pc_sel ? pc+4 : {jb_pc[31:1],1'b0}. Bit 0 is cleared per JALR.
    - pc+4 wraps modulo 2^32.
    - If t[1]=1: go to ERR, pc unchanged.
    - Else pc<=t and go to REQ.
- ERR:
  - misalign_err=1, inst_valid=0, imem_req_valid=0.
  - Stays in ERR until reset.
- inst_valid is 1 only in HOLD.
- imem_resp_valid outside WAIT is ignored: no state or inst change.
- core_ready outside HOLD is ignored.
- Throughput: with zero-wait memory, one instruction per 3 cycles (REQ, WAIT, HOLD with core_ready=1).
- All outputs are driven from registers or a direct decode of the state register; no combinational path from input to output except nothing. jb_pc and next_pc_sel are only sampled on the retire edge.

Test Plan:
- Reset release, RESET_PC=0, ready/resp always 1, core_ready=1, next_pc_sel=1:
  - Requests go to 0x0, 0x4, 0x8.
  - inst_valid pulses every 3rd cycle.
  - instret=3 after the third retire.
- Branch taken: in HOLD at pc=0x8, next_pc_sel=0, jb_pc=0x40, core_ready=1:
  - Next imem_req_addr=0x40.
  - pc=0x40 with its inst presented.
- JALR odd target: jb_pc=0x101, next_pc_sel=0:
  - Next request addr=0x100, no error.
- Misaligned: jb_pc=0x102, next_pc_sel=0:
  - ERR entered; misalign_err=1 sticky.
  - No further requests; instret still counts the retiring instruction.
- Backpressure and stall:
  - imem_req_ready=0 for 4 cycles: addr stable, valid held.
  - Response delayed 3 cycles; spurious imem_resp_valid during REQ ignored.
  - core_ready=0 for 5 cycles in HOLD: inst/pc stable, instret unchanged.
- Reset mid-operation and counter wrap:
  - Assert rst_n=0 in WAIT: next cycle all outputs at reset values and pc=RESET_PC.
  - Preload instret near max via 2^32-1 retires, or force: the next retire wraps it to 0.
